// File: rtl/xras_sla_pkg.sv
// rtl/xras_sla_pkg.sv - shared types, level constants and classification for the SLA tracker
package xras_sla_pkg;

  localparam int SLA_REL_W = 16;

  typedef enum logic [1:0] {
    SLA_ACTIVE   = 2'd0,
    SLA_WARNING  = 2'd1,
    SLA_BREACHED = 2'd2
  } sla_status_e;

  localparam logic [7:0] SLA_LVL_DEVICE   = 8'd0;
  localparam logic [7:0] SLA_LVL_GATEWAY  = 8'd1;
  localparam logic [7:0] SLA_LVL_EDGE     = 8'd2;
  localparam logic [7:0] SLA_LVL_FOG      = 8'd3;
  localparam logic [7:0] SLA_LVL_REGIONAL = 8'd4;
  localparam logic [7:0] SLA_LVL_CLOUD    = 8'd5;

  typedef struct packed {
    logic [31:0]          id;
    sla_status_e          status;
    logic [SLA_REL_W-1:0] rel;
    logic [SLA_REL_W-1:0] gap;
  } sla_evt_t;

  // Breach threshold is target minus drift, floored at zero.
  function automatic sla_status_e sla_classify(input logic [SLA_REL_W-1:0] rel,
                                               input logic [SLA_REL_W-1:0] target,
                                               input logic [SLA_REL_W-1:0] drift);
    logic [SLA_REL_W-1:0] thr;
    thr = (target > drift) ? target - drift : '0;
    if (rel < thr)         return SLA_BREACHED;
    else if (rel < target) return SLA_WARNING;
    else                   return SLA_ACTIVE;
  endfunction

endpackage

// File: rtl/xras_sla_evt_fifo.sv
// rtl/xras_sla_evt_fifo.sv - first-word-fall-through queue of SLA status events
module xras_sla_evt_fifo
  import xras_sla_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  sla_evt_t wr_data,
  input  logic     rd_en,
  output sla_evt_t rd_data,
  output logic     full,
  output logic     empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sla_evt_t      mem [DEPTH];
  logic [AW:0]   wptr, rptr;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // Head is masked while empty so the event outputs read zero when idle.
  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= wr_data;
        wptr              <= wptr + 1'b1;
      end
      if (rd_en && !empty) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/xras_sla_tracker_mc.sv
// rtl/xras_sla_tracker_mc.sv - multi-slot EWMA reliability SLA tracker with debounced status events
module xras_sla_tracker_mc
  import xras_sla_pkg::*;
#(
  parameter int NUM_SLA    = 8,
  parameter int REL_W      = SLA_REL_W,
  parameter int EWMA_SHIFT = 3,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W     = (NUM_SLA > 1) ? $clog2(NUM_SLA) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic                 cfg_enable,
  input  logic [7:0]           cfg_level,
  input  logic [REL_W-1:0]     cfg_target,
  input  logic [REL_W-1:0]     cfg_drift,
  input  logic                 meas_valid,
  input  logic [IDX_W-1:0]     meas_idx,
  input  logic [REL_W-1:0]     meas_sample,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [31:0]          evt_sla_id,
  output logic [1:0]           evt_status,
  output logic [REL_W-1:0]     evt_reliability,
  output logic [REL_W-1:0]     evt_gap,
  output logic [2*NUM_SLA-1:0] status_vec,
  output logic                 breach_any,
  output logic                 evt_overflow
);
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic             en_q     [NUM_SLA];
  logic [7:0]       lvl_q    [NUM_SLA];
  logic [REL_W-1:0] target_q [NUM_SLA];
  logic [REL_W-1:0] drift_q  [NUM_SLA];
  logic [REL_W-1:0] rel_q    [NUM_SLA];
  sla_status_e      st_q     [NUM_SLA];
  logic [DB_W-1:0]  deb_q    [NUM_SLA];
  logic [23:0]      seq_q    [NUM_SLA];

  logic                  cfg_hit, meas_hit, push, pop, fifo_full, fifo_empty;
  logic signed [REL_W:0]   d, d_sh;
  logic signed [REL_W+1:0] sum;
  logic [REL_W-1:0]      cur_rel, cur_target, rel_n;
  sla_status_e           cur_st, cls, st_n;
  logic [DB_W-1:0]       cur_deb, deb_n;
  sla_evt_t              push_evt, head_evt;

  assign cfg_hit  = cfg_we && (32'(cfg_idx) < NUM_SLA);
  // A config write to the sampled slot wins; the sample is dropped.
  assign meas_hit = meas_valid && (32'(meas_idx) < NUM_SLA) && en_q[meas_idx] &&
                    !(cfg_hit && (cfg_idx == meas_idx));

  always_comb begin
    cur_rel    = rel_q[meas_idx];
    cur_target = target_q[meas_idx];
    cur_st     = st_q[meas_idx];
    cur_deb    = deb_q[meas_idx];
    d          = $signed({1'b0, meas_sample}) - $signed({1'b0, cur_rel});
    d_sh       = d >>> EWMA_SHIFT;
    sum        = $signed({2'b00, cur_rel}) + $signed({d_sh[REL_W], d_sh});
    if (sum[REL_W+1])   rel_n = '0;
    else if (sum[REL_W]) rel_n = '1;
    else                 rel_n = sum[REL_W-1:0];
    cls   = sla_classify(rel_n, cur_target, drift_q[meas_idx]);
    st_n  = cur_st;
    deb_n = cur_deb;
    if (cls > cur_st) begin
      st_n  = cls;
      deb_n = '0;
    end else if (cls == cur_st) begin
      deb_n = '0;
    end else if (cur_deb == DB_W'(DEBOUNCE - 1)) begin
      st_n  = cls;
      deb_n = '0;
    end else begin
      deb_n = cur_deb + DB_W'(1);
    end
    push            = meas_hit && (st_n != cur_st);
    push_evt.id     = {lvl_q[meas_idx], seq_q[meas_idx]};
    push_evt.status = st_n;
    push_evt.rel    = rel_n;
    push_evt.gap    = (cur_target > rel_n) ? cur_target - rel_n : '0;
  end

  assign pop = evt_valid && evt_ready;

  xras_sla_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_evt_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push && (!fifo_full || pop)),
    .wr_data (push_evt),
    .rd_en   (pop),
    .rd_data (head_evt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid       = !fifo_empty;
  assign evt_sla_id      = head_evt.id;
  assign evt_status      = head_evt.status;
  assign evt_reliability = head_evt.rel;
  assign evt_gap         = head_evt.gap;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLA; i++) begin
        en_q[i]     <= 1'b0;
        lvl_q[i]    <= '0;
        target_q[i] <= '0;
        drift_q[i]  <= '0;
        rel_q[i]    <= '0;
        st_q[i]     <= SLA_ACTIVE;
        deb_q[i]    <= '0;
        seq_q[i]    <= '0;
      end
      evt_overflow <= 1'b0;
    end else begin
      if (cfg_hit) begin
        en_q[cfg_idx]     <= cfg_enable;
        lvl_q[cfg_idx]    <= cfg_level;
        target_q[cfg_idx] <= cfg_target;
        drift_q[cfg_idx]  <= cfg_drift;
        rel_q[cfg_idx]    <= cfg_target;
        st_q[cfg_idx]     <= SLA_ACTIVE;
        deb_q[cfg_idx]    <= '0;
        seq_q[cfg_idx]    <= '0;
      end
      if (meas_hit) begin
        rel_q[meas_idx] <= rel_n;
        st_q[meas_idx]  <= st_n;
        deb_q[meas_idx] <= deb_n;
        if (push) seq_q[meas_idx] <= seq_q[meas_idx] + 24'd1;
      end
      if (push && fifo_full && !pop) evt_overflow <= 1'b1;
    end
  end

  always_comb begin
    breach_any = 1'b0;
    for (int i = 0; i < NUM_SLA; i++) begin
      status_vec[2*i +: 2] = st_q[i];
      breach_any           = breach_any | (en_q[i] && (st_q[i] == SLA_BREACHED));
    end
  end

endmodule

// File: tb/tb_xras_sla_tracker_mc.sv
// tb/tb_xras_sla_tracker_mc.sv - randomized self-checking bench with a queue-based reference model
module tb_xras_sla_tracker_mc;

  logic        clk = 0;
  logic        rst;
  logic        cfg_we, cfg_enable, meas_valid, evt_ready;
  logic [2:0]  cfg_idx, meas_idx;
  logic [7:0]  cfg_level;
  logic [15:0] cfg_target, cfg_drift, meas_sample;
  logic        evt_valid, breach_any, evt_overflow;
  logic [31:0] evt_sla_id;
  logic [1:0]  evt_status;
  logic [15:0] evt_reliability, evt_gap;
  logic [15:0] status_vec;

  xras_sla_tracker_mc dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_enable(cfg_enable),
    .cfg_level(cfg_level), .cfg_target(cfg_target), .cfg_drift(cfg_drift),
    .meas_valid(meas_valid), .meas_idx(meas_idx), .meas_sample(meas_sample),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_sla_id(evt_sla_id),
    .evt_status(evt_status), .evt_reliability(evt_reliability), .evt_gap(evt_gap),
    .status_vec(status_vec), .breach_any(breach_any), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {int id; int st; int rel; int gap;} ev_t;
  bit   m_en  [8];
  int   m_lvl [8], m_tgt[8], m_drf[8], m_rel[8], m_st[8], m_deb[8], m_seq[8];
  ev_t  m_q[$];
  bit   m_ovf;

  function automatic int classify(int rel, int tgt, int drf);
    int thr = (tgt - drf < 0) ? 0 : tgt - drf;
    if (rel < thr) return 2;
    if (rel < tgt) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_en[i] = 0; m_lvl[i] = 0; m_tgt[i] = 0; m_drf[i] = 0;
      m_rel[i] = 0; m_st[i] = 0; m_deb[i] = 0; m_seq[i] = 0;
    end
    m_q.delete();
    m_ovf = 0;
  endtask

  task automatic model_step();
    bit  pop = (m_q.size() > 0) && evt_ready;
    bit  push = 0;
    ev_t ev;
    int  s, d, rn, c;
    if (cfg_we) begin
      s = cfg_idx;
      m_en[s] = cfg_enable; m_lvl[s] = cfg_level; m_tgt[s] = cfg_target; m_drf[s] = cfg_drift;
      m_rel[s] = cfg_target; m_st[s] = 0; m_deb[s] = 0; m_seq[s] = 0;
    end
    if (meas_valid && m_en[meas_idx] && !(cfg_we && cfg_idx == meas_idx)) begin
      s  = meas_idx;
      d  = int'(meas_sample) - m_rel[s];
      rn = m_rel[s] + (d >>> 3);
      if (rn < 0) rn = 0;
      if (rn > 65535) rn = 65535;
      c = classify(rn, m_tgt[s], m_drf[s]);
      if (c > m_st[s]) begin
        m_st[s] = c; m_deb[s] = 0; push = 1;
      end else if (c == m_st[s]) begin
        m_deb[s] = 0;
      end else begin
        m_deb[s]++;
        if (m_deb[s] == 4) begin
          m_st[s] = c; m_deb[s] = 0; push = 1;
        end
      end
      m_rel[s] = rn;
      if (push) begin
        ev.id  = (m_lvl[s] << 24) | m_seq[s];
        ev.st  = m_st[s];
        ev.rel = rn;
        ev.gap = (m_tgt[s] > rn) ? m_tgt[s] - rn : 0;
        m_seq[s] = (m_seq[s] + 1) % (1 << 24);
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 4) m_q.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    logic [15:0] sv = '0;
    bit          br = 0;
    for (int i = 0; i < 8; i++) begin
      sv[2*i +: 2] = 2'(m_st[i]);
      if (m_en[i] && m_st[i] == 2) br = 1;
    end
    check("status_vec", status_vec, sv);
    check("breach_any", breach_any, br);
    check("evt_valid", evt_valid, m_q.size() > 0);
    check("evt_overflow", evt_overflow, m_ovf);
    if (m_q.size() > 0) begin
      check("evt_id", evt_sla_id, m_q[0].id);
      check("evt_status", evt_status, m_q[0].st);
      check("evt_rel", evt_reliability, m_q[0].rel);
      check("evt_gap", evt_gap, m_q[0].gap);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    cfg_we = 0;
    meas_valid = 0;
  endtask

  task automatic do_cfg(input int idx, input bit en, input int lvl, input int tgt, input int drf);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_enable = en; cfg_level = 8'(lvl);
    cfg_target = 16'(tgt); cfg_drift = 16'(drf);
  endtask

  task automatic do_meas(input int idx, input int smp);
    meas_valid = 1; meas_idx = 3'(idx); meas_sample = 16'(smp);
  endtask

  initial begin
    rst = 1; cfg_we = 0; cfg_idx = 0; cfg_enable = 0; cfg_level = 0; cfg_target = 0;
    cfg_drift = 0; meas_valid = 0; meas_idx = 0; meas_sample = 0; evt_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_status_vec", status_vec, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_breach", breach_any, 0);
    check("rst_ovf", evt_overflow, 0);
    check("rst_evt_id", evt_sla_id, 0);
    rst = 0;

    do_cfg(2, 1, 3, 1000, 100); step();
    check("cfg_no_evt", evt_valid, 0);
    do_meas(2, 0); step();
    check("brk_id", evt_sla_id, 32'h0300_0000);
    check("brk_status", evt_status, 2);
    check("brk_rel", evt_reliability, 875);
    check("brk_gap", evt_gap, 125);
    check("brk_any", breach_any, 1);
    evt_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      do_meas(2, 2000); step();
      if (k < 4) check("deb_no_evt", evt_valid, 0);
    end
    check("deb_evt_valid", evt_valid, 1);
    check("deb_status", evt_status, 0);
    check("deb_id", evt_sla_id, 32'h0300_0001);

    do_cfg(0, 1, 0, 1000, 100); step();
    do_meas(0, 920); step();
    check("warn_status", evt_status, 1);
    check("warn_rel", evt_reliability, 990);
    check("warn_gap", evt_gap, 10);
    check("warn_vec", status_vec[1:0], 1);
    step();

    evt_ready = 0;
    for (int s = 3; s <= 7; s++) begin do_cfg(s, 1, s - 2, 1000, 100); step(); end
    for (int s = 3; s <= 7; s++) begin do_meas(s, 0); step(); end
    check("ovf_set", evt_overflow, 1);
    check("ovf_head", evt_sla_id, 32'h0100_0000);
    evt_ready = 1;
    repeat (4) step();
    check("drained", evt_valid, 0);

    do_cfg(1, 1, 2, 500, 50); do_meas(1, 0); step();
    check("cfg_wins_no_evt", evt_valid, 0);
    do_meas(1, 500); step();
    check("cfg_wins_rel", evt_valid, 0);
    do_cfg(7, 0, 5, 1000, 100); step();
    do_meas(7, 0); step();
    check("disabled_no_evt", evt_valid, 0);
    check("disabled_vec", status_vec[15:14], 0);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0)
        do_cfg($urandom_range(0, 7), $urandom_range(0, 5) != 0, $urandom_range(0, 5),
               $urandom_range(500, 3000), $urandom_range(0, 1500));
      if ($urandom_range(0, 3) != 0)
        do_meas($urandom_range(0, 7),
                ($urandom_range(0, 19) == 0) ? 65535 : $urandom_range(0, 4000));
      evt_ready = $urandom_range(0, 2) != 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
